// File: rtl/async_pkg.sv
// Shared types and constants for the bundled-data async/sync boundary blocks.
package async_pkg;

  typedef enum logic [1:0] {
    BD_IDLE    = 2'd0,
    BD_HOLD    = 2'd1,
    BD_RELEASE = 2'd2
  } bd_rx_state_t;

  localparam int SYNC_MIN = 2;

endpackage : async_pkg

// File: rtl/sync_nff.sv
// N-flop reset-to-0 single-bit synchroniser for signals crossing into clk.
module sync_nff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [stages-1:0] sync_q;

  // Shift the asynchronous bit in at the LSB; the MSB is the resolved copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= stages'({sync_q, d_i});
    end
  end

  assign q_o = sync_q[stages-1];

endmodule : sync_nff

// File: rtl/bd_sync_rx.sv
// Receiving end of a 4-phase bundled-data channel: synchronises req, captures
// the bundled word, offers it on valid/ready and returns a registered ack.
module bd_sync_rx
  import async_pkg::*;
#(
  parameter int size        = 1,
  parameter int sync_stages = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_in,
  input  logic [size-1:0] data_in,
  output logic            ack_out,
  output logic [size-1:0] data_out,
  output logic            valid_out,
  input  logic            ready_in,
  output logic            proto_err
);

  if (sync_stages < SYNC_MIN) begin : g_stage_check
    $error("bd_sync_rx: sync_stages must be >= %0d", SYNC_MIN);
  end

  bd_rx_state_t    state_q, state_d;
  logic [size-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            req_s;

  // The state/capture registers form the final synchroniser rank, so the
  // explicit chain is one flop shorter and req rise to valid is sync_stages edges.
  sync_nff #(
    .stages(sync_stages - 1)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d_i(req_in),
    .q_o(req_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BD_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BD_IDLE:    if (req_s)              state_d = BD_HOLD;
      BD_HOLD:    if (valid_q && ready_in) state_d = BD_RELEASE;
      BD_RELEASE: if (!req_s)             state_d = BD_IDLE;
      default:                            state_d = BD_IDLE;
    endcase
  end

  // data_in is only sampled on the IDLE->HOLD edge; it is stable then by bundling.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    err_d   = err_q;
    case (state_q)
      BD_IDLE: begin
        if (req_s) begin
          data_d  = data_in;
          valid_d = 1'b1;
        end
      end
      BD_HOLD: begin
        if (!req_s) err_d = 1'b1;
        if (valid_q && ready_in) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
        end
      end
      BD_RELEASE: begin
        if (!req_s) ack_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign ack_out   = ack_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign proto_err = err_q;

endmodule : bd_sync_rx

// File: tb/tb_bd_sync_rx.sv
// Bench for bd_sync_rx: directed protocol steps plus a jittered 4-phase sender
// whose delivered words are checked against an in-order expected queue.
module tb_bd_sync_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_in, ready_in, ack_out, valid_out, proto_err;
  logic [W-1:0] data_in, data_out;
  logic         req3, ready3, ack3, valid3, err3;
  logic [W-1:0] data3_in, data3_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];

  always #5 clk = ~clk;

  bd_sync_rx #(.size(W), .sync_stages(2)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .proto_err(proto_err)
  );

  bd_sync_rx #(.size(W), .sync_stages(3)) dut3 (
    .clk(clk), .rst(rst), .req_in(req3), .data_in(data3_in),
    .ack_out(ack3), .data_out(data3_out), .valid_out(valid3),
    .ready_in(ready3), .proto_err(err3)
  );

  // Record every word the downstream side accepts (as seen by the next edge).
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) rx_q.push_back(data_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (ack_out !== lvl && n < 200) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk(tag, 32'(ack_out), 32'(lvl));
  endtask

  task automatic jitter();
    int d = int'($urandom_range(0, 3));
    for (int i = 0; i < d; i++) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Behavioural 4-phase sender: data before req, hold until ack, then release.
  task automatic send_word(input logic [W-1:0] w);
    data_in = w;
    jitter();
    req_in = 1'b1;
    exp_q.push_back(w);
    wait_ack(1'b1, "stream_ack_rise");
    jitter();
    req_in = 1'b0;
    wait_ack(1'b0, "stream_ack_fall");
    data_in = W'($urandom);
  endtask

  initial begin
    logic [W-1:0] w;
    rst = 1'b1; req_in = 1'b1; ready_in = 1'b0; data_in = 8'h3C;
    req3 = 1'b0; ready3 = 1'b1; data3_in = 8'h99;
    tick(); tick(); tick();

    // Reset state with req held high
    chk("rst_ack", 32'(ack_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_err", 32'(proto_err), 0);
    rst = 1'b0;
    tick();
    chk("rst_rel_valid_e1", 32'(valid_out), 0);
    tick();
    chk("rst_rel_valid_e2", 32'(valid_out), 1);
    chk("rst_rel_data", 32'(data_out), 32'h3C);
    ready_in = 1'b1;
    tick();
    req_in = 1'b0;
    tick(); tick();
    chk("rst_rel_ack_fall", 32'(ack_out), 0);

    // Single token
    rx_q.delete();
    data_in = 8'hA5; ready_in = 1'b1; req_in = 1'b1;
    tick();
    chk("single_valid_e1", 32'(valid_out), 0);
    tick();
    chk("single_valid_e2", 32'(valid_out), 1);
    chk("single_data", 32'(data_out), 32'hA5);
    tick();
    chk("single_ack_rise", 32'(ack_out), 1);
    chk("single_valid_drop", 32'(valid_out), 0);
    req_in = 1'b0;
    tick();
    chk("single_ack_hold", 32'(ack_out), 1);
    tick();
    chk("single_ack_fall", 32'(ack_out), 0);
    chk("single_delivered", 32'(rx_q.size()), 1);

    // Backpressure
    data_in = 8'h5A; ready_in = 1'b0; req_in = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {23'd0, ack_out, valid_out, data_out}, {23'd0, 1'b0, 1'b1, 8'h5A});
    end
    ready_in = 1'b1;
    tick();
    chk("bp_ack_rise", 32'(ack_out), 1);
    req_in = 1'b0;
    tick(); tick();
    chk("bp_ack_fall", 32'(ack_out), 0);

    // Stream with random jitter and random downstream readiness
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? W'(i + 1) : W'($urandom);
      send_word(w);
    end
    ready_in = 1'b1;
    tick(); tick(); tick();
    chk("stream_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("stream_word", 32'(rx_q[i]), 32'(exp_q[i]));
    chk("stream_data_held", 32'(data_out), 32'(exp_q[exp_q.size()-1]));
    chk("stream_valid_idle", 32'(valid_out), 0);
    chk("stream_no_err", 32'(proto_err), 0);

    // Protocol violation: req drops while the word is held
    rx_q.delete();
    data_in = 8'hC3; ready_in = 1'b0; req_in = 1'b1;
    tick(); tick();
    chk("err_valid", 32'(valid_out), 1);
    req_in = 1'b0;
    tick();
    chk("err_not_yet", 32'(proto_err), 0);
    tick();
    chk("err_set", 32'(proto_err), 1);
    ready_in = 1'b1;
    tick();
    chk("err_ack_rise", 32'(ack_out), 1);
    tick(); tick(); tick();
    chk("err_ack_fall", 32'(ack_out), 0);
    chk("err_sticky", 32'(proto_err), 1);
    chk("err_delivered_once", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) chk("err_word", 32'(rx_q[0]), 32'hC3);

    // Reset while in RELEASE with req still high
    data_in = 8'h77; ready_in = 1'b1; req_in = 1'b1;
    tick(); tick(); tick();
    chk("rr_ack_before", 32'(ack_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_ack_async", 32'(ack_out), 0);
    chk("rr_err_cleared", 32'(proto_err), 0);
    rx_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("rr_valid_e1", 32'(valid_out), 0);
    tick();
    chk("rr_recapture", {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'h77});
    tick();
    chk("rr_ack_rise", 32'(ack_out), 1);
    req_in = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rr_delivered_once", 32'(rx_q.size()), 1);

    // Three-stage synchroniser latency
    req3 = 1'b1;
    tick(); tick();
    chk("s3_valid_e2", 32'(valid3), 0);
    tick();
    chk("s3_valid_e3", 32'(valid3), 1);
    chk("s3_data", 32'(data3_out), 32'h99);
    tick();
    chk("s3_ack_rise", 32'(ack3), 1);
    req3 = 1'b0;
    tick(); tick();
    chk("s3_ack_hold", 32'(ack3), 1);
    tick();
    chk("s3_ack_fall", 32'(ack3), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_bd_sync_rx
